// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: the VGA scan-out fetches one word per 2^S x 2^S block with fixed latency,
// and the pixel writer takes every RAM cycle the display leaves free.
module vga_fb_arbiter #(
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int SCALE_LOG2     = 2,
  parameter int ADDR_W         = 15,
  parameter int WR_VBLANK_ONLY = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              video_on_in,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [11:0]       wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [11:0]       mem_wdata,
  input  logic [11:0]       mem_rdata,
  output logic [11:0]       rgb,
  output logic              h_sync,
  output logic              v_sync,
  output logic              frame_start
);

  localparam int                FB_W     = H_ACTIVE >> SCALE_LOG2;
  localparam int                FB_H     = V_ACTIVE >> SCALE_LOG2;
  localparam logic [ADDR_W-1:0] FB_W_A   = ADDR_W'(FB_W);
  localparam logic [ADDR_W:0]   FB_SIZE  = (ADDR_W+1)'(FB_W * FB_H);
  localparam logic [9:0]        SUB_MASK = 10'((1 << SCALE_LOG2) - 1);
  localparam logic [9:0]        V_ACT    = 10'(V_ACTIVE);
  localparam bit                VB_ONLY  = WR_VBLANK_ONLY[0];

  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [11:0]       mem_wdata_q, mem_wdata_d;
  logic              wr_ack_q, wr_ack_d, wr_err_q, wr_err_d;
  logic              slot1_q, slot1_d, slot2_q, slot2_d;
  logic              von1_q, von1_d, von2_q, von2_d;
  logic              hs1_q, hs1_d, hs2_q, hs2_d, h_sync_q, h_sync_d;
  logic              vs1_q, vs1_d, vs2_q, vs2_d, v_sync_q, v_sync_d;
  logic              fs1_q, fs1_d, fs2_q, fs2_d, frame_start_q, frame_start_d;
  logic [11:0]       pix_q, pix_d, rgb_q, rgb_d;

  logic              disp_slot_s, vblank_ok_s, grant_s, in_range_s;
  logic [ADDR_W-1:0] disp_addr_s;

  assign disp_slot_s = video_on_in & ((pos_x & SUB_MASK) == 10'd0);
  assign vblank_ok_s = ~VB_ONLY | (pos_y >= V_ACT);
  // The previous-cycle ack blocks a re-grant while the writer is still dropping its request.
  assign grant_s     = wr_req & ~disp_slot_s & ~wr_ack_q & vblank_ok_s;
  assign in_range_s  = {1'b0, wr_addr} < FB_SIZE;
  assign disp_addr_s = ADDR_W'(pos_y >> SCALE_LOG2) * FB_W_A + ADDR_W'(pos_x >> SCALE_LOG2);

  // Next-state logic for RAM arbitration and the display pipeline.
  always_comb begin
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_ack_d    = 1'b0;
    wr_err_d    = wr_err_q;
    if (disp_slot_s) begin
      mem_en_d   = 1'b1;
      mem_addr_d = disp_addr_s;
    end else if (grant_s) begin
      wr_ack_d = 1'b1;
      if (in_range_s) begin
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = wr_addr;
        mem_wdata_d = wr_data;
      end else begin
        wr_err_d = 1'b1;
      end
    end else begin
      mem_en_d = 1'b0;
    end

    slot1_d       = disp_slot_s;
    slot2_d       = slot1_q;
    von1_d        = video_on_in;
    von2_d        = von1_q;
    hs1_d         = h_sync_in;
    hs2_d         = hs1_q;
    h_sync_d      = hs2_q;
    vs1_d         = v_sync_in;
    vs2_d         = vs1_q;
    v_sync_d      = vs2_q;
    fs1_d         = video_on_in & (pos_x == 10'd0) & (pos_y == 10'd0);
    fs2_d         = fs1_q;
    frame_start_d = fs2_q;
    // rgb is the third stage, so it sees the pixel value being loaded this edge.
    pix_d         = slot2_q ? mem_rdata : pix_q;
    rgb_d         = von2_q ? pix_d : 12'h000;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= 12'h000;
      wr_ack_q      <= 1'b0;
      wr_err_q      <= 1'b0;
      slot1_q       <= 1'b0;
      slot2_q       <= 1'b0;
      von1_q        <= 1'b0;
      von2_q        <= 1'b0;
      hs1_q         <= 1'b1;
      hs2_q         <= 1'b1;
      h_sync_q      <= 1'b1;
      vs1_q         <= 1'b1;
      vs2_q         <= 1'b1;
      v_sync_q      <= 1'b1;
      fs1_q         <= 1'b0;
      fs2_q         <= 1'b0;
      frame_start_q <= 1'b0;
      pix_q         <= 12'h000;
      rgb_q         <= 12'h000;
    end else begin
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      wr_ack_q      <= wr_ack_d;
      wr_err_q      <= wr_err_d;
      slot1_q       <= slot1_d;
      slot2_q       <= slot2_d;
      von1_q        <= von1_d;
      von2_q        <= von2_d;
      hs1_q         <= hs1_d;
      hs2_q         <= hs2_d;
      h_sync_q      <= h_sync_d;
      vs1_q         <= vs1_d;
      vs2_q         <= vs2_d;
      v_sync_q      <= v_sync_d;
      fs1_q         <= fs1_d;
      fs2_q         <= fs2_d;
      frame_start_q <= frame_start_d;
      pix_q         <= pix_d;
      rgb_q         <= rgb_d;
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign wr_ack      = wr_ack_q;
  assign wr_err      = wr_err_q;
  assign rgb         = rgb_q;
  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: drivers queue expected pin values, fetches and write acks,
// and a negedge monitor pops and compares them as the DUT presents them.
module tb_vga_fb_arbiter;

  typedef struct {int cyc; logic [11:0] rgb; logic hs; logic vs; logic fs;} pin_t;
  typedef struct {int cyc; logic [14:0] addr;} fetch_t;
  typedef struct {logic [14:0] addr; logic [11:0] data; logic en;} ack_t;

  logic        clk = 1'b0, reset = 1'b1;
  logic        video_on_in = 1'b0, h_sync_in = 1'b1, v_sync_in = 1'b1;
  logic [9:0]  pos_x = 10'd0, pos_y = 10'd0;
  logic        wr_req = 1'b0;
  logic [14:0] wr_addr = 15'd0;
  logic [11:0] wr_data = 12'h000;
  logic        wr_ack, wr_err, mem_en, mem_we, h_sync, v_sync, frame_start;
  logic [14:0] mem_addr;
  logic [11:0] mem_wdata, rgb;
  logic [11:0] mem_rdata = 12'h000;
  logic [11:0] ram [0:32767];

  logic [9:0]  vb_pos_y = 10'd0;
  logic        vb_wr_req = 1'b0;
  logic        vb_wr_ack, vb_wr_err, vb_mem_en, vb_mem_we, vb_h_sync, vb_v_sync, vb_fs;
  logic [14:0] vb_mem_addr;
  logic [11:0] vb_mem_wdata, vb_rgb;

  int     cyc = 0, n_pass = 0, n_tot = 0, n_ack = 0, last_ack_cyc = 0;
  logic [11:0] exp_pix = 12'h000;
  pin_t   pin_q[$];
  fetch_t fetch_q[$];
  ack_t   ack_q[$];

  vga_fb_arbiter u_dut (
    .clk(clk), .reset(reset), .video_on_in(video_on_in), .h_sync_in(h_sync_in),
    .v_sync_in(v_sync_in), .pos_x(pos_x), .pos_y(pos_y), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rgb(rgb), .h_sync(h_sync), .v_sync(v_sync),
    .frame_start(frame_start)
  );

  vga_fb_arbiter #(.WR_VBLANK_ONLY(1)) u_vb (
    .clk(clk), .reset(reset), .video_on_in(1'b0), .h_sync_in(1'b1),
    .v_sync_in(1'b1), .pos_x(10'd700), .pos_y(vb_pos_y), .wr_req(vb_wr_req),
    .wr_addr(15'd7), .wr_data(12'h777), .wr_ack(vb_wr_ack), .wr_err(vb_wr_err),
    .mem_en(vb_mem_en), .mem_we(vb_mem_we), .mem_addr(vb_mem_addr), .mem_wdata(vb_mem_wdata),
    .mem_rdata(12'h000), .rgb(vb_rgb), .h_sync(vb_h_sync), .v_sync(vb_v_sync),
    .frame_start(vb_fs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 12'(i);
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Drive one display cycle and queue the pins/fetch it must produce.
  task automatic pix(input logic von, input logic [9:0] x, input logic [9:0] y,
                     input logic hs, input logic vs);
    pin_t pe; fetch_t fe; logic [14:0] a;
    @(posedge clk); #1;
    video_on_in = von; pos_x = x; pos_y = y; h_sync_in = hs; v_sync_in = vs;
    if (von && x[1:0] == 2'b00) begin
      a = 15'(y >> 2) * 15'd160 + 15'(x >> 2);
      exp_pix = ram[a];
      fe.cyc = cyc + 1; fe.addr = a;
      fetch_q.push_back(fe);
    end
    pe.cyc = cyc + 3; pe.rgb = von ? exp_pix : 12'h000;
    pe.hs = hs; pe.vs = vs; pe.fs = von && x == 10'd0 && y == 10'd0;
    pin_q.push_back(pe);
  endtask

  task automatic present(input logic [14:0] a, input logic [11:0] d, input logic en);
    ack_t ae;
    ae.addr = a; ae.data = d; ae.en = en;
    ack_q.push_back(ae);
    wr_addr = a; wr_data = d; wr_req = 1'b1;
  endtask

  task automatic wait_ack();
    logic got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      if (wr_ack) begin got = 1'b1; last_ack_cyc = cyc; end
    end
    wr_req = 1'b0;
    chk("wr_ack_seen", 32'(got), 32'd1);
  endtask

  // Monitor: compare queued expectations when the DUT presents them.
  always @(negedge clk) begin : monitor
    pin_t pe; fetch_t fe; ack_t ae;
    if (!reset) begin
      if (pin_q.size() > 0 && pin_q[0].cyc == cyc) begin
        pe = pin_q.pop_front();
        chk("rgb", 32'(rgb), 32'(pe.rgb));
        chk("h_sync", 32'(h_sync), 32'(pe.hs));
        chk("v_sync", 32'(v_sync), 32'(pe.vs));
        chk("frame_start", 32'(frame_start), 32'(pe.fs));
      end
      if (fetch_q.size() > 0 && fetch_q[0].cyc == cyc) begin
        fe = fetch_q.pop_front();
        chk("fetch_en", 32'(mem_en), 32'd1);
        chk("fetch_we", 32'(mem_we), 32'd0);
        chk("fetch_addr", 32'(mem_addr), 32'(fe.addr));
      end
      if (wr_ack) begin
        n_ack++;
        chk("ack_expected", 32'(ack_q.size() != 0), 32'd1);
        if (ack_q.size() != 0) begin
          ae = ack_q.pop_front();
          chk("wr_mem_en", 32'(mem_en), 32'(ae.en));
          chk("wr_mem_we", 32'(mem_we), 32'(ae.en));
          if (ae.en) begin
            chk("wr_mem_addr", 32'(mem_addr), 32'(ae.addr));
            chk("wr_mem_wdata", 32'(mem_wdata), 32'(ae.data));
          end
        end
      end
    end
  end

  initial begin : stim
    int c_rel, c_slot, first_ack, acks0, early, c480, vb_got, vb_cyc;

    // Reset with a pending write request.
    present(15'd5000, 12'h123, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("rst_rgb", 32'(rgb), 32'd0);
      chk("rst_h_sync", 32'(h_sync), 32'd1);
      chk("rst_v_sync", 32'(v_sync), 32'd1);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_wr_ack", 32'(wr_ack), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    c_rel = cyc;
    @(negedge clk);
    chk("release_mem_en", 32'(mem_en), 32'd0);
    wait_ack();
    chk("first_ack_delay", 32'(last_ack_cyc - c_rel), 32'd1);

    // Line 8 sweep: 0x140..0x143 each held for four pixels.
    for (int x = 0; x < 16; x++) pix(1'b1, 10'(x), 10'd8, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) pix(1'b0, 10'(640 + i), 10'd8, (i >= 2 && i < 5) ? 1'b0 : 1'b1, 1'b1);
    // Frame origin: frame_start, vsync low.
    for (int x = 0; x < 8; x++) pix(1'b1, 10'(x), 10'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) pix(1'b0, 10'(640 + i), 10'd0, 1'b1, 1'b1);

    // Write presented in a display-slot cycle.
    acks0 = n_ack;
    fork
      begin
        for (int x = 0; x < 16; x++) pix(1'b1, 10'(x), 10'd16, 1'b1, 1'b1);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        c_slot = cyc;
        present(15'd100, 12'hABC, 1'b1);
        wait_ack();
        chk("slot_ack_cycle", 32'(last_ack_cyc - c_slot), 32'd2);
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("slot_ack_count", 32'(n_ack - acks0), 32'd1);

    // Twenty back-to-back writes during horizontal blanking.
    acks0 = n_ack;
    first_ack = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) pix(1'b0, 10'(640 + i), 10'd20, (i % 16 < 4) ? 1'b0 : 1'b1, 1'b1);
      end
      begin
        for (int i = 0; i < 20; i++) begin
          present(15'(1000 + i), 12'(12'h500 + i), 1'b1);
          wait_ack();
          if (i == 0) first_ack = last_ack_cyc;
        end
        chk("burst_ack_span", 32'(last_ack_cyc - first_ack), 32'd38);
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("burst_ack_count", 32'(n_ack - acks0), 32'd20);

    // Out-of-range write then a valid one: wr_err sticky.
    chk("wr_err_clear", 32'(wr_err), 32'd0);
    present(15'd19200, 12'hFFF, 1'b0);
    wait_ack();
    @(negedge clk);
    chk("wr_err_set", 32'(wr_err), 32'd1);
    @(posedge clk); #1;
    present(15'd1100, 12'h0AA, 1'b1);
    wait_ack();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("wr_err_sticky", 32'(wr_err), 32'd1);

    chk("ram_5000", 32'(ram[5000]), 32'h123);
    chk("ram_100", 32'(ram[100]), 32'hABC);
    for (int i = 0; i < 20; i++) chk("ram_burst", 32'(ram[1000 + i]), 32'(12'h500 + i));
    chk("ram_1100", 32'(ram[1100]), 32'h0AA);
    chk("ram_19200_untouched", 32'(ram[19200]), 32'hB00);

    // Vblank-only instance: request from line 100, granted only at line 480.
    early = 0;
    for (int y = 100; y < 480; y++) begin
      @(posedge clk); #1;
      vb_pos_y = 10'(y);
      vb_wr_req = 1'b1;
      if (vb_wr_ack) early++;
    end
    @(posedge clk); #1;
    if (vb_wr_ack) early++;
    vb_pos_y = 10'd480;
    c480 = cyc;
    chk("vb_no_early_ack", 32'(early), 32'd0);
    vb_got = 0; vb_cyc = 0;
    for (int i = 0; i < 4 && vb_got == 0; i++) begin
      @(posedge clk); #1;
      if (vb_wr_ack) begin
        vb_got = 1; vb_cyc = cyc;
        chk("vb_mem_we", 32'(vb_mem_we), 32'd1);
        chk("vb_mem_addr", 32'(vb_mem_addr), 32'd7);
        chk("vb_mem_wdata", 32'(vb_mem_wdata), 32'h777);
      end
    end
    vb_wr_req = 1'b0;
    chk("vb_ack_seen", 32'(vb_got), 32'd1);
    chk("vb_ack_within_2", 32'((vb_cyc - c480) >= 1 && (vb_cyc - c480) <= 2), 32'd1);

    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("pin_queue_drained", 32'(pin_q.size()), 32'd0);
    chk("fetch_queue_drained", 32'(fetch_q.size()), 32'd0);
    chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous frame-buffer RAM between two users:
  - the VGA display scan-out, which has hard real-time priority;
  - a pixel writer port, such as a drawing engine or CPU bridge.
- Takes pixel timing from the VGA timing generator. Fetches downscaled frame-buffer pixels and drives 12-bit rgb plus re-aligned syncs to the pins.
- Grants the writer every RAM cycle the display does not need.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- SCALE_LOG2, 2, upscale factor exponent; each frame-buffer pixel covers a 2^S x 2^S screen block.
  - FB_W = H_ACTIVE>>S = 160.
  - FB_H = V_ACTIVE>>S = 120.
- ADDR_W, 15, frame-buffer address width; must satisfy FB_W*FB_H <= 2^ADDR_W.
- WR_VBLANK_ONLY, 0, when 1 the writer is granted only while pos_y >= V_ACTIVE (tear-free mode).

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high.
- video_on_in  in  1  active-area flag from the timing generator.
- h_sync_in  in  1  hsync from the timing generator (active low).
- v_sync_in  in  1  vsync from the timing generator (active low).
- pos_x  in  10  current column.
- pos_y  in  10  current line.
- wr_req  in  1  writer request; wr_addr/wr_data are held stable until wr_ack.
- wr_addr  in  ADDR_W  linear address, row*FB_W+col.
- wr_data  in  12  pixel to write.
- wr_ack  out  1  one-cycle pulse: request consumed.
- wr_err  out  1  sticky: an out-of-range write address was seen.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  12  RAM write data.
- mem_rdata  in  12  RAM read data, valid the cycle after the RAM samples mem_en=1, mem_we=0.
- rgb  out  12  pixel output.
- h_sync  out  1  hsync delayed to match rgb.
- v_sync  out  1  vsync delayed to match rgb.
- frame_start  out  1  one-cycle pulse on the first active pixel of a frame, aligned with rgb.

Behaviour:
- All outputs are registered.
- Reset values:
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - wr_ack=0, wr_err=0.
  - rgb=0, frame_start=0.
  - h_sync=1, v_sync=1.
  - Internal pipeline regs cleared; video_on stages = 0, sync stages = 1.
- Display slot:
  - Condition: video_on_in=1 and pos_x[S-1:0]==0.
  - Registers mem_en=1, mem_we=0, mem_addr=(pos_y>>S)*FB_W + (pos_x>>S).
  - The address arithmetic is performed in ADDR_W bits; no overflow for legal pos values.
- Fixed pipeline, LATENCY = 3 clocks from pos/video_on_in to rgb:
  - cycle t: pos presented;
  - t+1: mem_addr valid;
  - t+2: mem_rdata valid;
  - t+3: pixel register valid.
- Pixel register:
  - Loads mem_rdata only in the cycle two clocks after a display slot.
  - Otherwise it holds, so each fetched value is displayed for 2^S consecutive clocks.
- rgb = pixel register when video_on delayed by 3 is 1; otherwise rgb = 0.
- h_sync/v_sync: h_sync_in/v_sync_in delayed by exactly 3 registers.
- frame_start: 1 at t+3 for the input cycle with video_on_in=1, pos_x=0, pos_y=0.
- Writer grant:
  - Conditions, all required in a given cycle:
    - wr_req=1;
    - not a display slot;
    - wr_ack was not asserted in the previous cycle, so a held request is not double-consumed;
    - if WR_VBLANK_ONLY=1, also pos_y >= V_ACTIVE.
  - Effect when granted: next edge registers mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1.
  - Writer throughput at S=2: worst case 1 write per 2 clocks during active video; 1 per 2 clocks during blanking. No starvation, because at most 1 of 4 active cycles is a display slot.
- Out-of-range write (wr_addr >= FB_W*FB_H):
  - wr_ack pulses as normal; mem_en=0 and mem_we=0 for that cycle.
  - wr_err sets and stays 1 until reset.
- Idle cycle (neither display slot nor write grant): mem_en=0, mem_we=0. mem_addr and mem_wdata hold.
- Simultaneous display slot and wr_req: display wins; the writer retries the next cycle.
- Reset mid-operation:
  - Any in-flight write is abandoned; no wr_ack is issued for it.
  - The writer must re-present after reset deasserts.
  - Display resumes at the first display slot after release; rgb=0 until the pipeline refills.

Test Plan:
- Reset held for 5 clocks while wr_req=1 -> during reset rgb=0, h_sync=1, v_sync=1, mem_en=0, wr_ack=0; first mem_en=1 no earlier than 1 clock after release.
- RAM model preloaded with word value = address[11:0]; pos_y=8, pos_x sweeps 0..15 with video_on_in=1 ->
  - mem_addr = 320, 321, 322, 323 on every 4th clock;
  - rgb = 0x140 for 4 clocks, then 0x141, 0x142, 0x143, starting exactly 3 clocks after pos_x=0.
- wr_req held with wr_addr=100, wr_data=0xABC during active video, request presented in a display-slot cycle -> write issued the following cycle; exactly one wr_ack; RAM word 100 = 0xABC; no display fetch skipped.
- Back-to-back requests, 20 writes during horizontal blanking -> 20 acks, addresses in order, no duplicates, no rgb disturbance.
- WR_VBLANK_ONLY=1, wr_req asserted at pos_y=100 -> no wr_ack until pos_y=480, then ack within 2 clocks.
- wr_addr=19200 -> wr_ack pulses, mem_we stays 0, wr_err=1 and remains set through later valid writes.
